// File: rtl/stopwatch_lap.sv
// Lap stopwatch: min:sec:fraction timer with pause/resume and a LAP_DEPTH-entry lap buffer.
// Buttons are active-low; a press is a single-cycle event taken from a falling sample.
module stopwatch_lap #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MIN_MAX   = 99,
    parameter int LAP_DEPTH = 4,
    localparam int MW   = (MIN_MAX > 0) ? $clog2(MIN_MAX + 1) : 1,
    localparam int FW   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1,
    localparam int SELW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int CW   = $clog2(LAP_DEPTH + 1)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            fStart,
    input  logic            fStop,
    input  logic            fLap,
    input  logic            fClear,
    input  logic [SELW-1:0] iLapSel,
    output logic [MW-1:0]   oMin,
    output logic [5:0]      oSec,
    output logic [FW-1:0]   oFrac,
    output logic            oRunning,
    output logic            oOvf,
    output logic [CW-1:0]   oLapCount,
    output logic            oLapFull,
    output logic [MW-1:0]   oLapMin,
    output logic [5:0]      oLapSec,
    output logic [FW-1:0]   oLapFrac
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [3:0]    btn_s;
    logic [3:0]    prev_r;
    logic [3:0]    arm_r;
    logic [3:0]    press_s;
    logic          start_s;
    logic          stop_s;
    logic          lap_s;
    logic          clear_s;

    logic [1:0]    state_r;
    logic          running_r;
    logic [PW-1:0] presc_r;
    logic [MW-1:0] min_r;
    logic [5:0]    sec_r;
    logic [FW-1:0] frac_r;
    logic          ovf_r;

    logic          tick_s;
    logic [MW-1:0] min_nx_s;
    logic [5:0]    sec_nx_s;
    logic [FW-1:0] frac_nx_s;
    logic          ovf_nx_s;

    logic          clear_all_s;
    logic          lap_wr_s;
    logic [CW-1:0] lap_cnt_r;
    logic [MW-1:0] lap_min_r  [LAP_DEPTH];
    logic [5:0]    lap_sec_r  [LAP_DEPTH];
    logic [FW-1:0] lap_frac_r [LAP_DEPTH];
    logic [MW-1:0] lap_min_s;
    logic [5:0]    lap_sec_s;
    logic [FW-1:0] lap_frac_s;

    assign btn_s   = {fClear, fLap, fStop, fStart};
    assign press_s = ~btn_s & prev_r & arm_r;
    assign start_s = press_s[0];
    assign stop_s  = press_s[1];
    assign lap_s   = press_s[2];
    assign clear_s = press_s[3];

    // Press detection; arm_r blocks a button held low across reset until it is released once.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prev_r <= 4'b1111;
            arm_r  <= btn_s;
        end else begin
            prev_r <= btn_s;
            arm_r  <= arm_r | btn_s;
        end
    end

    assign tick_s = (state_r == RUN) && (presc_r == PW'(DIV - 1));

    // Carry chain frac -> sec -> min, with minute wrap raising the sticky overflow.
    always_comb begin
        frac_nx_s = frac_r;
        sec_nx_s  = sec_r;
        min_nx_s  = min_r;
        ovf_nx_s  = ovf_r;
        if (tick_s) begin
            if (frac_r == FW'(TICK_HZ - 1)) begin
                frac_nx_s = '0;
                if (sec_r == 6'd59) begin
                    sec_nx_s = 6'd0;
                    if (min_r == MW'(MIN_MAX)) begin
                        min_nx_s = '0;
                        ovf_nx_s = 1'b1;
                    end else begin
                        min_nx_s = min_r + MW'(1);
                    end
                end else begin
                    sec_nx_s = sec_r + 6'd1;
                end
            end else begin
                frac_nx_s = frac_r + FW'(1);
            end
        end else begin
            ovf_nx_s = ovf_r;
        end
    end

    // Mode control, prescaler and running time.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            running_r <= 1'b0;
            presc_r   <= '0;
            min_r     <= '0;
            sec_r     <= 6'd0;
            frac_r    <= '0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear_s) begin
                        ovf_r <= 1'b0;
                    end
                    if (start_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end
                end
                RUN: begin
                    presc_r <= tick_s ? '0 : presc_r + PW'(1);
                    min_r   <= min_nx_s;
                    sec_r   <= sec_nx_s;
                    frac_r  <= frac_nx_s;
                    ovf_r   <= ovf_nx_s;
                    if (stop_s) begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (clear_s) begin
                        state_r <= IDLE;
                        presc_r <= '0;
                        min_r   <= '0;
                        sec_r   <= 6'd0;
                        frac_r  <= '0;
                        ovf_r   <= 1'b0;
                    end else if (start_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign clear_all_s = clear_s && ((state_r == IDLE) || (state_r == PAUSE));
    assign lap_wr_s    = lap_s && (state_r == RUN) && (lap_cnt_r < CW'(LAP_DEPTH));

    // Lap buffer: captures the pre-increment time into the next free slot.
    always_ff @(posedge Clk) begin
        if (Rst || clear_all_s) begin
            lap_cnt_r <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_min_r[i]  <= '0;
                lap_sec_r[i]  <= 6'd0;
                lap_frac_r[i] <= '0;
            end
        end else if (lap_wr_s) begin
            lap_min_r[lap_cnt_r[SELW-1:0]]  <= min_r;
            lap_sec_r[lap_cnt_r[SELW-1:0]]  <= sec_r;
            lap_frac_r[lap_cnt_r[SELW-1:0]] <= frac_r;
            lap_cnt_r                       <= lap_cnt_r + CW'(1);
        end else begin
            lap_cnt_r <= lap_cnt_r;
        end
    end

    // Readout of unfilled slots is forced to zero.
    always_comb begin
        lap_min_s  = '0;
        lap_sec_s  = 6'd0;
        lap_frac_s = '0;
        if (CW'(iLapSel) < lap_cnt_r) begin
            lap_min_s  = lap_min_r[iLapSel];
            lap_sec_s  = lap_sec_r[iLapSel];
            lap_frac_s = lap_frac_r[iLapSel];
        end else begin
            lap_min_s  = '0;
        end
    end

    assign oMin      = min_r;
    assign oSec      = sec_r;
    assign oFrac     = frac_r;
    assign oRunning  = running_r;
    assign oOvf      = ovf_r;
    assign oLapCount = lap_cnt_r;
    assign oLapFull  = (lap_cnt_r == CW'(LAP_DEPTH));
    assign oLapMin   = lap_min_s;
    assign oLapSec   = lap_sec_s;
    assign oLapFrac  = lap_frac_s;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: dut_a uses DIV=10, dut_b uses DIV=1 so the minute wrap is reachable quickly.
// Both share stimulus and are compared against an elapsed-cycle reference model.
module tb_stopwatch_lap;

    localparam int WRAP = 100 * 60 * 2;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       fStart = 1'b1;
    logic       fStop = 1'b1;
    logic       fLap = 1'b1;
    logic       fClear = 1'b1;
    logic [1:0] iLapSel = 2'd0;

    logic       a_min, a_run, a_ovf, a_full, a_lmin;
    logic [5:0] a_sec, a_lsec;
    logic [6:0] a_frac, a_lfrac;
    logic [2:0] a_cnt;
    logic       b_min, b_run, b_ovf, b_full, b_lmin;
    logic [5:0] b_sec, b_lsec;
    logic [6:0] b_frac, b_lfrac;
    logic [2:0] b_cnt;

    always #5 Clk = ~Clk;

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_MAX(1), .LAP_DEPTH(4)) dut_a (
        .Clk(Clk), .Rst(Rst), .fStart(fStart), .fStop(fStop), .fLap(fLap), .fClear(fClear),
        .iLapSel(iLapSel), .oMin(a_min), .oSec(a_sec), .oFrac(a_frac), .oRunning(a_run),
        .oOvf(a_ovf), .oLapCount(a_cnt), .oLapFull(a_full), .oLapMin(a_lmin),
        .oLapSec(a_lsec), .oLapFrac(a_lfrac)
    );

    stopwatch_lap #(.CLK_HZ(100), .TICK_HZ(100), .MIN_MAX(1), .LAP_DEPTH(4)) dut_b (
        .Clk(Clk), .Rst(Rst), .fStart(fStart), .fStop(fStop), .fLap(fLap), .fClear(fClear),
        .iLapSel(iLapSel), .oMin(b_min), .oSec(b_sec), .oFrac(b_frac), .oRunning(b_run),
        .oOvf(b_ovf), .oLapCount(b_cnt), .oLapFull(b_full), .oLapMin(b_lmin),
        .oLapSec(b_lsec), .oLapFrac(b_lfrac)
    );

    // Reference model: elapsed RUN cycles per device, lap tick snapshots, button history.
    longint     cyc [2];
    int         st [2];
    longint     lapv [2][4];
    int         lapn [2];
    logic [3:0] mprev;
    logic [3:0] marm;
    int         checks = 0;
    int         errors = 0;

    function automatic int div_of(int d);
        return (d == 0) ? 10 : 1;
    endfunction

    function automatic logic [19:0] exp_vec(int d);
        longint tk;
        longint t;
        tk = cyc[d] / div_of(d);
        t  = tk % WRAP;
        return {st[d] == 1, tk >= WRAP, 1'(t / 6000), 6'((t / 100) % 60), 7'(t % 100),
                3'(lapn[d]), lapn[d] == 4};
    endfunction

    function automatic logic [19:0] dut_vec(int d);
        if (d == 0) return {a_run, a_ovf, a_min, a_sec, a_frac, a_cnt, a_full};
        else        return {b_run, b_ovf, b_min, b_sec, b_frac, b_cnt, b_full};
    endfunction

    function automatic logic [13:0] exp_lap(int d, int s);
        longint t;
        if (s >= lapn[d]) return 14'd0;
        t = lapv[d][s] % WRAP;
        return {1'(t / 6000), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    function automatic logic [13:0] dut_lap(int d);
        if (d == 0) return {a_lmin, a_lsec, a_lfrac};
        else        return {b_lmin, b_lsec, b_lfrac};
    endfunction

    task automatic model_edge();
        logic [3:0] b;
        logic [3:0] p;
        b = {fClear, fLap, fStop, fStart};
        if (Rst) begin
            for (int d = 0; d < 2; d++) begin
                st[d] = 0; cyc[d] = 0; lapn[d] = 0;
                for (int s = 0; s < 4; s++) lapv[d][s] = 0;
            end
            mprev = 4'b1111;
            marm  = b;
        end else begin
            p = ~b & mprev & marm;
            mprev = b;
            marm  = marm | b;
            for (int d = 0; d < 2; d++) begin
                case (st[d])
                    0: begin
                        if (p[3]) lapn[d] = 0;
                        if (p[0]) st[d] = 1;
                    end
                    1: begin
                        if (p[2] && lapn[d] < 4) begin
                            lapv[d][lapn[d]] = cyc[d] / div_of(d);
                            lapn[d]++;
                        end
                        cyc[d]++;
                        if (p[1]) st[d] = 2;
                    end
                    default: begin
                        if (p[3]) begin
                            st[d] = 0; cyc[d] = 0; lapn[d] = 0;
                        end else if (p[0]) begin
                            st[d] = 1;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== 20'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", d, dut_vec(d));
            end
        end
        fStart = 1'b0;
        step();
        fStart = 1'b1;
        repeat (1000) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL first_run[%0d]: got %h want %h", d, dut_vec(d), exp_vec(d));
                end
            end
        end
        checks++;
        if ({a_run, a_min, a_sec, a_frac} !== {1'b1, 1'b0, 6'd1, 7'd0}) begin
            errors++;
            $display("FAIL one_second: got run=%0d %0d:%0d.%0d want 1 0:1.0", a_run, a_min, a_sec, a_frac);
        end
    endtask

    task automatic test_pause();
        int frac0;
        while (cyc[0] % 10 != 3) step();
        fStop = 1'b0;
        step();
        fStop = 1'b1;
        frac0 = int'(a_frac);
        repeat (50) begin
            step();
            checks++;
            if (a_frac !== 7'(frac0) || dut_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL pause_hold: got frac=%0d b=%h want frac=%0d b=%h", a_frac, dut_vec(1), frac0, exp_vec(1));
            end
        end
        fStart = 1'b0;
        step();
        fStart = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (a_frac !== ((i < 6) ? 7'(frac0) : 7'((frac0 + 1) % 100))) begin
                errors++;
                $display("FAIL resume_tick: cycle %0d got frac=%0d base=%0d", i, a_frac, frac0);
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL resume_state[%0d]: got %h want %h", d, dut_vec(d), exp_vec(d));
            end
        end
    endtask

    task automatic test_laps();
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(5, 40)) step();
            if (k == 1) begin
                while (cyc[0] % 10 != 9) step();
            end
            fLap = 1'b0;
            step();
            fLap = 1'b1;
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL lap_press%0d[%0d]: got %h want %h", k, d, dut_vec(d), exp_vec(d));
                end
            end
            if (k == 1) begin
                for (int s = 2; s < 4; s++) begin
                    iLapSel = 2'(s);
                    #1;
                    checks++;
                    if ({a_lmin, a_lsec, a_lfrac} !== 14'd0) begin
                        errors++;
                        $display("FAIL lap_unfilled[%0d]: got %h want 0", s, {a_lmin, a_lsec, a_lfrac});
                    end
                end
            end
        end
        checks++;
        if ({a_cnt, a_full} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL lap_full: got cnt=%0d full=%0d want 4 1", a_cnt, a_full);
        end
        for (int s = 0; s < 4; s++) begin
            iLapSel = 2'(s);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_lap(d) !== exp_lap(d, s)) begin
                    errors++;
                    $display("FAIL lap_data%0d[%0d]: got %h want %h", s, d, dut_lap(d), exp_lap(d, s));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        while (cyc[1] < WRAP - 1 && n < 20000) begin
            step();
            n++;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL long_run[%0d]: got %h want %h", d, dut_vec(d), exp_vec(d));
                end
            end
        end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d cycles want fewer than 20000", n);
        end
        checks++;
        if ({b_min, b_sec, b_frac, b_ovf} !== {1'b1, 6'd59, 7'd99, 1'b0}) begin
            errors++;
            $display("FAIL pre_wrap: got %0d:%0d.%0d ovf=%0d want 1:59.99 ovf=0", b_min, b_sec, b_frac, b_ovf);
        end
        step();
        checks++;
        if ({b_min, b_sec, b_frac, b_ovf} !== {1'b0, 6'd0, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL post_wrap: got %0d:%0d.%0d ovf=%0d want 0:0.0 ovf=1", b_min, b_sec, b_frac, b_ovf);
        end
        fClear = 1'b0;
        step();
        fClear = 1'b1;
        step();
        checks++;
        if ({b_run, b_ovf, b_cnt, a_run} !== {1'b1, 1'b1, 3'd4, 1'b1} || dut_vec(1) !== exp_vec(1)) begin
            errors++;
            $display("FAIL clear_in_run: got %h want %h", dut_vec(1), exp_vec(1));
        end
        fStop = 1'b0;
        step();
        fStop = 1'b1;
        step();
        fClear = 1'b0;
        step();
        fClear = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== 20'd0) begin
                errors++;
                $display("FAIL pause_clear[%0d]: got %h want 0", d, dut_vec(d));
            end
        end
    endtask

    task automatic test_stop_lap();
        fStart = 1'b0;
        step();
        fStart = 1'b1;
        repeat ($urandom_range(20, 200)) step();
        fStop = 1'b0;
        fLap  = 1'b0;
        step();
        fStop = 1'b1;
        fLap  = 1'b1;
        step();
        checks++;
        if ({a_run, a_cnt} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL stop_lap: got run=%0d cnt=%0d want 0 1", a_run, a_cnt);
        end
        iLapSel = 2'd0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== exp_vec(d) || dut_lap(d) !== exp_lap(d, 0)) begin
                errors++;
                $display("FAIL stop_lap_data[%0d]: got %h/%h want %h/%h", d, dut_vec(d), dut_lap(d), exp_vec(d), exp_lap(d, 0));
            end
        end
        fStart = 1'b0;
        fClear = 1'b0;
        step();
        fStart = 1'b1;
        fClear = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== 20'd0) begin
                errors++;
                $display("FAIL start_clear_pause[%0d]: got %h want 0", d, dut_vec(d));
            end
        end
    endtask

    task automatic test_held_start();
        fStart = 1'b0;
        repeat (30) step();
        fStart = 1'b1;
        step();
        fStop = 1'b0;
        step();
        fStop = 1'b1;
        step();
        checks++;
        if ({a_run, a_sec, a_frac} !== {1'b0, 6'd0, 7'd3}) begin
            errors++;
            $display("FAIL held_start: got run=%0d %0d.%0d want 0 0.3", a_run, a_sec, a_frac);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL held_start_model[%0d]: got %h want %h", d, dut_vec(d), exp_vec(d));
            end
        end
        fStart = 1'b0;
        fClear = 1'b0;
        step();
        fStart = 1'b1;
        fClear = 1'b1;
        step();
        checks++;
        if (dut_vec(0) !== 20'd0) begin
            errors++;
            $display("FAIL held_start_clear: got %h want 0", dut_vec(0));
        end
    endtask

    task automatic test_reset_midrun();
        fStart = 1'b0;
        step();
        fStart = 1'b1;
        repeat ($urandom_range(15, 60)) step();
        Rst    = 1'b1;
        fLap   = 1'b0;
        fStart = 1'b0;
        step();
        Rst = 1'b0;
        repeat (20) step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== 20'd0 || exp_vec(d) !== 20'd0) begin
                errors++;
                $display("FAIL reset_midrun[%0d]: got %h want 0", d, dut_vec(d));
            end
        end
        fLap   = 1'b1;
        fStart = 1'b1;
        step();
        fStart = 1'b0;
        step();
        fStart = 1'b1;
        repeat (25) step();
        checks++;
        if ({a_run, a_frac} !== {1'b1, 7'd2} || dut_vec(1) !== exp_vec(1)) begin
            errors++;
            $display("FAIL restart_after_reset: got run=%0d frac=%0d want 1 2", a_run, a_frac);
        end
    endtask

    initial begin
        test_reset();
        test_pause();
        test_laps();
        test_wrap();
        test_stop_lap();
        test_held_start();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
